// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, ALU and response channels around alu_arbiter.
// The arbiter uses the slave modport; the requesters, the ALU and the consumer sit on master.
interface alu_arbiter_if #(
  parameter int DW  = 32,
  parameter int OPW = 5
);
  logic           req0_valid;
  logic           req0_ready;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic [OPW-1:0] req0_op;

  logic           req1_valid;
  logic           req1_ready;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic [OPW-1:0] req1_op;

  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_s;
  logic [DW-1:0]  alu_w;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [DW-1:0]  rsp_data;
  logic           rsp_err;
  logic           busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_w, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_s,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_w, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_s,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, with error detection and a tagged response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0; otherwise round-robin.
module alu_arbiter #(
  parameter int DW       = 32,
  parameter int OPW      = 5,
  parameter int MD_LAT   = 4,
  parameter int BASE_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam int MAX_LAT = (MD_LAT > BASE_LAT) ? MD_LAT : BASE_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [DW-1:0]  alu_a_q, alu_b_q;
  logic [OPW-1:0] alu_s_q;
  logic           rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [DW-1:0]  rsp_data_q;

  logic           grant0, grant1, accept, acc_id;
  logic [DW-1:0]  acc_a, acc_b;
  logic [OPW-1:0] acc_op;
  logic           is_md, is_div, is_ill, err_d;
  logic [CW-1:0]  cnt_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = bus.req0_valid;
  assign grant1 = bus.req1_valid & ~bus.req0_valid;
`else
  logic last_q;
  // On a tie the requester that did not win last time is served.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
`endif

  assign bus.req0_ready = (state_q == IDLE) & grant0;
  assign bus.req1_ready = (state_q == IDLE) & grant1;
  assign accept         = bus.req0_ready | bus.req1_ready;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned and infers a latch.
  always_comb begin
    acc_id = 1'b0;
    acc_a  = bus.req0_a;
    acc_b  = bus.req0_b;
    acc_op = bus.req0_op;
    if (grant1) begin
      acc_id = 1'b1;
      acc_a  = bus.req1_a;
      acc_b  = bus.req1_b;
      acc_op = bus.req1_op;
    end
    is_md  = (acc_op[OPW-1:2] == (OPW-2)'(1));
    is_div = (acc_op[OPW-1:1] == (OPW-1)'(3));
    is_ill = acc_op[OPW-1];
    err_d  = is_ill | (is_div & (acc_b == '0));
    cnt_d  = is_md ? CW'(MD_LAT - 1) : CW'(BASE_LAT - 1);
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q  <= acc_a;
            alu_b_q  <= acc_b;
            alu_s_q  <= acc_op;
            rsp_id_q <= acc_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q   <= acc_id;
`endif
            if (err_d) begin
              // Illegal opcode or divide by zero answers immediately; the ALU output is never used.
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              cnt_q   <= cnt_d;
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rsp_data_q  <= bus.alu_w;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_s     = alu_s_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
